serial_parity_checker: RTL and testbench

Parametrised, clocked successor to the 5-bit combinational even-parity checker. Receives frames serially, one bit per accepted beat: DATA_W data bits LSB-first, then one parity bit. Checks each frame in even or odd mode, chosen per frame, and presents the deserialised word with an error flag. Keeps a saturating error count and sits between a serial link front-end and the frame consumer.

---
 rtl/parity_pkg.sv | 18 +
 rtl/err_sat_counter.sv | 27 ++
 rtl/serial_parity_checker.sv | 129 ++++++++++++
 tb/tb_serial_parity_checker.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/parity_pkg.sv
// Shared types and helpers for the serial parity checker.
// Holds the frame FSM states and parity mode encodings.
package parity_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PAR
  } state_t;

  localparam logic EVEN = 1'b0;
  localparam logic ODD  = 1'b1;

  function automatic int idx_w(input int dw);
    return (dw < 2) ? 1 : $clog2(dw);
  endfunction

endpackage

// File: rtl/err_sat_counter.sv
// Saturating event counter with a clear that beats increment.
// Used to tally frames that failed their parity check.
module err_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/serial_parity_checker.sv
// Serial frame receiver: LSB-first data bits then one parity bit,
// checked in a per-frame even/odd mode, with a saturating error tally.
module serial_parity_checker
  import parity_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_bit,
  input  logic              in_sof,
  input  logic              odd_mode,
  input  logic              cnt_clr,
  output logic              busy,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam int IW = idx_w(DATA_W);
  localparam logic [IW-1:0] LAST = IW'(DATA_W - 1);

  state_t r_state;
  state_t w_next;

  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] r_out_data;
  logic [IW-1:0]     r_idx;
  logic              r_acc;
  logic              r_odd;
  logic              r_out_valid;
  logic              r_out_err;

  logic w_sof;
  logic w_par_beat;
  logic w_tot;
  logic w_err;
  logic w_busy;

  // A sof beat always wins, so a frame can be restarted from any state.
  assign w_sof      = in_valid & in_sof;
  assign w_par_beat = in_valid & ~in_sof & (r_state == PAR);
  assign w_tot      = r_acc ^ in_bit;
  assign w_err      = (r_odd == ODD) ? ~w_tot : w_tot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (w_sof) begin
      w_next = DATA;
    end else if (in_valid) begin
      unique case (r_state)
        DATA: begin
          if (r_idx == LAST) begin
            w_next = PAR;
          end
        end
        PAR:     w_next = IDLE;
        default: w_next = r_state;
      endcase
    end
  end

  always_comb begin
    w_busy = (r_state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift     <= '0;
      r_out_data  <= '0;
      r_idx       <= '0;
      r_acc       <= 1'b0;
      r_odd       <= EVEN;
      r_out_valid <= 1'b0;
      r_out_err   <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (w_sof) begin
        r_shift <= DATA_W'(in_bit);
        r_acc   <= in_bit;
        r_odd   <= odd_mode;
        r_idx   <= IW'(1);
      end else if (in_valid) begin
        unique case (r_state)
          DATA: begin
            r_shift[r_idx] <= in_bit;
            r_acc          <= r_acc ^ in_bit;
            r_idx          <= r_idx + 1'b1;
          end
          PAR: begin
            r_out_valid <= 1'b1;
            r_out_data  <= r_shift;
            r_out_err   <= w_err;
            r_acc       <= 1'b0;
            r_idx       <= '0;
          end
          default: ;
        endcase
      end
    end
  end

  err_sat_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (w_par_beat & w_err),
    .clr  (cnt_clr),
    .count(err_cnt)
  );

  assign busy      = w_busy;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_err   = r_out_err;

endmodule

// File: tb/tb_serial_parity_checker.sv
// Randomised self-checking bench for serial_parity_checker.
// Three instances (8/8, 5/8, 8/2) share one serial input stream.
module tb_serial_parity_checker;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, in_bit, in_sof, odd_mode, cnt_clr;

  logic       b8, v8, e8;
  logic [7:0] d8, c8;
  logic       b5, v5, e5;
  logic [4:0] d5;
  logic [7:0] c5;
  logic       b2, v2, e2;
  logic [7:0] d2;
  logic [1:0] c2;

  always #5 clk = ~clk;

  serial_parity_checker #(.DATA_W(8), .CNT_W(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit),
    .in_sof(in_sof), .odd_mode(odd_mode), .cnt_clr(cnt_clr),
    .busy(b8), .out_valid(v8), .out_data(d8), .out_err(e8), .err_cnt(c8));

  serial_parity_checker #(.DATA_W(5), .CNT_W(8)) u5 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit),
    .in_sof(in_sof), .odd_mode(odd_mode), .cnt_clr(cnt_clr),
    .busy(b5), .out_valid(v5), .out_data(d5), .out_err(e5), .err_cnt(c5));

  serial_parity_checker #(.DATA_W(8), .CNT_W(2)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit),
    .in_sof(in_sof), .odd_mode(odd_mode), .cnt_clr(cnt_clr),
    .busy(b2), .out_valid(v2), .out_data(d2), .out_err(e2), .err_cnt(c2));

  typedef struct {
    int         cyc;
    logic [7:0] d;
    logic       e;
    logic [7:0] c;
  } obs_t;

  obs_t q8[$];
  obs_t q5[$];
  obs_t q2[$];
  obs_t ob;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clk) begin
    obs_t t;
    cyc++;
    #1;
    if (v8) begin
      t.cyc = cyc; t.d = d8; t.e = e8; t.c = c8;
      q8.push_back(t);
    end
    if (v5) begin
      t.cyc = cyc; t.d = {3'b0, d5}; t.e = e5; t.c = c5;
      q5.push_back(t);
    end
    if (v2) begin
      t.cyc = cyc; t.d = d2; t.e = e2; t.c = {6'b0, c2};
      q2.push_back(t);
    end
  end

  // Reference: count ones over data+parity; even mode wants an even total.
  function automatic logic exp_err(input int w, input logic [7:0] d,
                                   input logic p, input logic o);
    int ones;
    ones = int'(p);
    for (int i = 0; i < w; i++) ones += int'(d[i]);
    return o ? logic'(ones % 2 == 0) : logic'(ones % 2 == 1);
  endfunction

  task automatic drive(input logic v, input logic b, input logic s,
                       input logic o, input logic c);
    @(negedge clk);
    in_valid = v; in_bit = b; in_sof = s; odd_mode = o; cnt_clr = c;
  endtask

  task automatic gap(input int pct);
    if ($urandom_range(99) < pct)
      repeat ($urandom_range(3, 1))
        drive(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
  endtask

  task automatic send(input int w, input logic [7:0] d, input logic p,
                      input logic o, input int pct, input logic flip,
                      input logic clr);
    logic om;
    om = flip ? ~o : o;
    drive(1'b1, d[0], 1'b1, o, 1'b0);
    for (int i = 1; i < w; i++) begin
      gap(pct);
      drive(1'b1, d[i], 1'b0, om, 1'b0);
    end
    gap(pct);
    drive(1'b1, p, 1'b0, om, clr);
  endtask

  task automatic settle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic clr_cnt();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    settle();
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({b8, v8, d8, e8, c8} !== 19'd0) begin
      n_bad++;
      $display("FAIL reset_in: got %h want 0", {b8, v8, d8, e8, c8});
    end
    @(negedge clk);
    rst_n = 1'b1;
    settle();
    n_cmp++;
    if ({b5, v5, d5, e5, c5, b2, v2, d2, e2, c2} !== 30'd0) begin
      n_bad++;
      $display("FAIL reset_out: got %h want 0",
               {b5, v5, d5, e5, c5, b2, v2, d2, e2, c2});
    end
  endtask

  task automatic test_even();
    clr_cnt();
    q8.delete();
    send(8, 8'hA5, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    settle();
    n_cmp++;
    if (q8.size() != 1) begin
      n_bad++;
      $display("FAIL even_ok_n: got %0d want 1", q8.size());
    end else begin
      ob = q8.pop_front();
      n_cmp++;
      if ({ob.d, ob.e, ob.c} !== {8'hA5, 1'b0, 8'd0}) begin
        n_bad++;
        $display("FAIL even_ok: got %h want %h", {ob.d, ob.e, ob.c},
                 {8'hA5, 1'b0, 8'd0});
      end
    end
    send(8, 8'hA5, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    settle();
    n_cmp++;
    if (q8.size() != 1) begin
      n_bad++;
      $display("FAIL even_err_n: got %0d want 1", q8.size());
    end else begin
      ob = q8.pop_front();
      n_cmp++;
      if ({ob.d, ob.e, ob.c} !== {8'hA5, 1'b1, 8'd1}) begin
        n_bad++;
        $display("FAIL even_err: got %h want %h", {ob.d, ob.e, ob.c},
                 {8'hA5, 1'b1, 8'd1});
      end
    end
    repeat (3) settle();
    n_cmp++;
    if ({v8, d8, e8, b8} !== {1'b0, 8'hA5, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL hold: got %h want %h", {v8, d8, e8, b8},
               {1'b0, 8'hA5, 1'b1, 1'b0});
    end
  endtask

  task automatic test_odd();
    logic [7:0] dd [4];
    logic       pp [4];
    logic       oo [4];
    logic       ff [4];
    dd = '{8'h01, 8'h01, 8'h01, 8'h01};
    pp = '{1'b0, 1'b1, 1'b0, 1'b1};
    oo = '{1'b1, 1'b1, 1'b1, 1'b0};
    ff = '{1'b0, 1'b0, 1'b1, 1'b1};
    for (int k = 0; k < 4; k++) begin
      q8.delete();
      send(8, dd[k], pp[k], oo[k], 0, ff[k], 1'b0);
      settle();
      n_cmp++;
      if (q8.size() != 1) begin
        n_bad++;
        $display("FAIL odd_n[%0d]: got %0d want 1", k, q8.size());
      end else begin
        ob = q8.pop_front();
        n_cmp++;
        if ({ob.d, ob.e} !== {dd[k], exp_err(8, dd[k], pp[k], oo[k])}) begin
          n_bad++;
          $display("FAIL odd[%0d]: got %h want %h", k, {ob.d, ob.e},
                   {dd[k], exp_err(8, dd[k], pp[k], oo[k])});
        end
      end
    end
  endtask

  task automatic test_exhaustive5();
    int   ec;
    logic ee;
    clr_cnt();
    q5.delete();
    ec = 0;
    for (int m = 0; m < 2; m++)
      for (int p = 0; p < 2; p++)
        for (int d = 0; d < 32; d++) begin
          send(5, 8'(d), 1'(p), 1'(m), 0, 1'b0, 1'b0);
          settle();
          ee = exp_err(5, 8'(d), 1'(p), 1'(m));
          if (ee) ec++;
          n_cmp++;
          if (q5.size() != 1) begin
            n_bad++;
            $display("FAIL ex5_n d=%0d p=%0d m=%0d: got %0d want 1",
                     d, p, m, q5.size());
            q5.delete();
          end else begin
            ob = q5.pop_front();
            if ({ob.d, ob.e, ob.c} !== {8'(d), ee, 8'(ec)}) begin
              n_bad++;
              $display("FAIL ex5 d=%0d p=%0d m=%0d: got %h want %h",
                       d, p, m, {ob.d, ob.e, ob.c}, {8'(d), ee, 8'(ec)});
            end
          end
        end
  endtask

  task automatic test_restart();
    logic [7:0] d;
    q8.delete();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'($urandom), 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (b8 !== 1'b1) begin
      n_bad++;
      $display("FAIL restart_busy: got %b want 1", b8);
    end
    d = 8'($urandom);
    send(8, d, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    settle();
    n_cmp++;
    if (q8.size() != 1) begin
      n_bad++;
      $display("FAIL restart_n: got %0d want 1", q8.size());
    end else begin
      ob = q8.pop_front();
      n_cmp++;
      if ({ob.d, ob.e} !== {d, exp_err(8, d, 1'b0, 1'b0)}) begin
        n_bad++;
        $display("FAIL restart: got %h want %h", {ob.d, ob.e},
                 {d, exp_err(8, d, 1'b0, 1'b0)});
      end
    end
  endtask

  task automatic test_gaps();
    logic [7:0] d;
    logic       p, o, f, ee;
    int         ec;
    clr_cnt();
    ec = 0;
    for (int k = 0; k < 20; k++) begin
      q8.delete();
      d = 8'($urandom); p = 1'($urandom);
      o = 1'($urandom); f = 1'($urandom);
      send(8, d, p, o, 40, f, 1'b0);
      settle();
      ee = exp_err(8, d, p, o);
      if (ee && ec < 255) ec++;
      n_cmp++;
      if (q8.size() != 1) begin
        n_bad++;
        $display("FAIL gaps_n[%0d]: got %0d want 1", k, q8.size());
      end else begin
        ob = q8.pop_front();
        if ({ob.d, ob.e, ob.c} !== {d, ee, 8'(ec)}) begin
          n_bad++;
          $display("FAIL gaps[%0d]: got %h want %h", k, {ob.d, ob.e, ob.c},
                   {d, ee, 8'(ec)});
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] da, db;
    logic       pa, pb;
    obs_t       oa;
    q8.delete();
    da = 8'($urandom); db = 8'($urandom);
    pa = 1'($urandom); pb = 1'($urandom);
    send(8, da, pa, 1'b0, 0, 1'b0, 1'b0);
    send(8, db, pb, 1'b1, 0, 1'b0, 1'b0);
    settle();
    n_cmp++;
    if (q8.size() != 2) begin
      n_bad++;
      $display("FAIL b2b_n: got %0d want 2", q8.size());
    end else begin
      oa = q8.pop_front();
      ob = q8.pop_front();
      n_cmp++;
      if (ob.cyc - oa.cyc != 9) begin
        n_bad++;
        $display("FAIL b2b_gap: got %0d want 9", ob.cyc - oa.cyc);
      end
      n_cmp++;
      if ({oa.d, oa.e, ob.d, ob.e} !== {da, exp_err(8, da, pa, 1'b0),
                                        db, exp_err(8, db, pb, 1'b1)}) begin
        n_bad++;
        $display("FAIL b2b_data: got %h want %h", {oa.d, oa.e, ob.d, ob.e},
                 {da, exp_err(8, da, pa, 1'b0), db, exp_err(8, db, pb, 1'b1)});
      end
    end
  endtask

  task automatic test_saturate();
    logic [7:0] want [7];
    logic       clr [7];
    want = '{8'd1, 8'd2, 8'd3, 8'd3, 8'd3, 8'd0, 8'd1};
    clr  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    clr_cnt();
    q2.delete();
    for (int k = 0; k < 7; k++) begin
      send(8, 8'h01, 1'b0, 1'b0, 0, 1'b0, clr[k]);
      settle();
      n_cmp++;
      if (q2.size() != 1) begin
        n_bad++;
        $display("FAIL sat_n[%0d]: got %0d want 1", k, q2.size());
        q2.delete();
      end else begin
        ob = q2.pop_front();
        if ({ob.e, ob.c} !== {1'b1, want[k]}) begin
          n_bad++;
          $display("FAIL sat[%0d]: got %h want %h", k, {ob.e, ob.c},
                   {1'b1, want[k]});
        end
      end
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] d;
    logic       p, ee;
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    n_cmp++;
    if ({b8, v8, d8, e8, c8} !== 19'd0) begin
      n_bad++;
      $display("FAIL async_rst: got %h want 0", {b8, v8, d8, e8, c8});
    end
    @(negedge clk);
    rst_n = 1'b1;
    q8.delete();
    d = 8'($urandom); p = 1'($urandom);
    send(8, d, p, 1'b1, 0, 1'b0, 1'b0);
    settle();
    ee = exp_err(8, d, p, 1'b1);
    n_cmp++;
    if (q8.size() != 1) begin
      n_bad++;
      $display("FAIL post_rst_n: got %0d want 1", q8.size());
    end else begin
      ob = q8.pop_front();
      n_cmp++;
      if ({ob.d, ob.e, ob.c} !== {d, ee, 7'd0, ee}) begin
        n_bad++;
        $display("FAIL post_rst: got %h want %h", {ob.d, ob.e, ob.c},
                 {d, ee, 7'd0, ee});
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_bit = 1'b0; in_sof = 1'b0;
    odd_mode = 1'b0; cnt_clr = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_even();
    test_odd();
    test_exhaustive5();
    test_restart();
    test_gaps();
    test_back_to_back();
    test_saturate();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
